// File: rtl/wrapper_mpu6050_i2c.sv
// rtl/wrapper_mpu6050_i2c.sv - I2C master that reads or wakes MPU-6050 registers
// A rising edge on en runs one bus transaction; each bit takes four QUARTER-cycle phases.
`timescale 1ns/1ps
module wrapper_mpu6050_i2c #(
  parameter int         QUARTER  = 10,
  parameter logic [6:0] DEV_ADDR = 7'h68
) (
  input  logic       clk_pll,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] register_selector,
  output logic       scl,
  output logic       tristate,
  inout  wire        sda,
  output logic [7:0] data
);
  localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(QUARTER - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK1, S_REG, S_ACK2, S_RSTART,
    S_ADDR_R, S_ACK3, S_READ, S_MNACK, S_WDATA, S_ACK4, S_STOP
  } state_t;

  state_t          state, state_next;
  logic            en_q;
  logic [3:0]      sel_q;
  logic [QW-1:0]   q_cnt;
  logic [1:0]      qtr;
  logic [2:0]      bit_cnt;
  logic            ack_bit;
  logic [7:0]      rx_shift;
  logic            sda_int;
  logic            en_rise, bit_end, sample_pt, last_bit, is_write;
  logic [7:0]      reg_addr, tx_byte;

  assign en_rise   = en & ~en_q;
  assign bit_end   = (qtr == 2'd3) && (q_cnt == Q_LAST);
  assign sample_pt = (qtr == 2'd2) && (q_cnt == Q_LAST);
  assign last_bit  = (bit_cnt == 3'd7);
  assign is_write  = (sel_q == 4'd14);

  always_comb begin
    reg_addr = 8'h3B + {4'd0, sel_q};
    if (sel_q == 4'd14)      reg_addr = 8'h6B;
    else if (sel_q == 4'd15) reg_addr = 8'h75;
  end

  always_ff @(posedge clk_pll) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Bit counter restarts whenever the FSM moves on, so multi-bit states always see 0..7.
  always_ff @(posedge clk_pll) begin
    if (rst) begin
      en_q     <= 1'b0;
      sel_q    <= 4'd0;
      q_cnt    <= '0;
      qtr      <= 2'd0;
      bit_cnt  <= 3'd0;
      ack_bit  <= 1'b0;
      rx_shift <= 8'h00;
      data     <= 8'h00;
    end else begin
      en_q <= en;
      if (state == S_IDLE) begin
        q_cnt   <= '0;
        qtr     <= 2'd0;
        bit_cnt <= 3'd0;
        if (en_rise) sel_q <= register_selector;
      end else begin
        q_cnt <= (q_cnt == Q_LAST) ? '0 : q_cnt + 1'b1;
        if (q_cnt == Q_LAST) qtr <= qtr + 2'd1;
        if (bit_end) bit_cnt <= (state_next != state) ? 3'd0 : bit_cnt + 3'd1;
        if (sample_pt) begin
          ack_bit <= sda;
          if (state == S_READ) rx_shift <= {rx_shift[6:0], sda};
        end
        if (state == S_MNACK && state_next == S_STOP) data <= rx_shift;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (en_rise) state_next = S_START;
      S_START:  if (bit_end) state_next = S_ADDR_W;
      S_ADDR_W: if (bit_end && last_bit) state_next = S_ACK1;
      S_ACK1:   if (bit_end) state_next = ack_bit ? S_STOP : S_REG;
      S_REG:    if (bit_end && last_bit) state_next = S_ACK2;
      S_ACK2:   if (bit_end) state_next = ack_bit ? S_STOP : (is_write ? S_WDATA : S_RSTART);
      S_RSTART: if (bit_end) state_next = S_ADDR_R;
      S_ADDR_R: if (bit_end && last_bit) state_next = S_ACK3;
      S_ACK3:   if (bit_end) state_next = ack_bit ? S_STOP : S_READ;
      S_READ:   if (bit_end && last_bit) state_next = S_MNACK;
      S_MNACK:  if (bit_end) state_next = S_STOP;
      S_WDATA:  if (bit_end && last_bit) state_next = S_ACK4;
      S_ACK4:   if (bit_end) state_next = ack_bit ? S_STOP : S_STOP;
      S_STOP:   if (bit_end) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // A fresh START keeps SCL high in its first quarter; a repeated START begins with SCL low.
  always_comb begin
    scl      = 1'b1;
    sda_int  = 1'b1;
    tristate = 1'b0;
    tx_byte  = 8'hFF;
    case (state)
      S_ADDR_W: tx_byte = {DEV_ADDR, 1'b0};
      S_REG:    tx_byte = reg_addr;
      S_ADDR_R: tx_byte = {DEV_ADDR, 1'b1};
      S_WDATA:  tx_byte = 8'h00;
      default:  tx_byte = 8'hFF;
    endcase
    case (state)
      S_START, S_RSTART: begin
        scl     = (qtr == 2'd1) || (qtr == 2'd2) || ((qtr == 2'd0) && (state == S_START));
        sda_int = (qtr < 2'd2);
      end
      S_STOP: begin
        scl     = (qtr != 2'd0);
        sda_int = (qtr >= 2'd2);
      end
      S_ADDR_W, S_REG, S_ADDR_R, S_WDATA: begin
        scl     = (qtr == 2'd1) || (qtr == 2'd2);
        sda_int = tx_byte[3'd7 - bit_cnt];
      end
      S_ACK1, S_ACK2, S_ACK3, S_ACK4, S_READ: begin
        scl      = (qtr == 2'd1) || (qtr == 2'd2);
        tristate = 1'b1;
      end
      S_MNACK: begin
        scl = (qtr == 2'd1) || (qtr == 2'd2);
      end
      default: begin
        scl      = 1'b1;
        sda_int  = 1'b1;
        tristate = 1'b0;
      end
    endcase
  end

  assign sda = tristate ? 1'bz : sda_int;

endmodule

// File: tb/tb_wrapper_mpu6050_i2c.sv
// tb/tb_wrapper_mpu6050_i2c.sv - bench for wrapper_mpu6050_i2c
// A bus decoder and slave model rebuild each I2C frame and compare it with the expected register access.
`timescale 1ns/1ps
module tb_wrapper_mpu6050_i2c;
  localparam int M_START = 'h1000;
  localparam int M_STOP  = 'h2000;

  logic       clk_pll = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] register_selector = 4'd0;
  logic       scl, tristate;
  logic [7:0] data;
  wire        sda;
  logic       slave_bit = 1'b1;

  assign sda = tristate ? slave_bit : 1'bz;

  wrapper_mpu6050_i2c dut (
    .clk_pll(clk_pll), .rst(rst), .en(en), .register_selector(register_selector),
    .scl(scl), .tristate(tristate), .sda(sda), .data(data)
  );

  always #10 clk_pll = ~clk_pll;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  always @(posedge clk_pll) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus-side model inputs, owned by the initial block.
  logic [3:0] cur_sel = 4'd0;
  logic [7:0] cur_byte = 8'h00;
  int         nack_at = -1;
  bit         mon_en = 1'b0;
  int         exp_q[$];

  // Bus decoder / slave state, owned by the monitor.
  int         frames[$];
  int         stop_count = 0;
  bit         in_txn = 1'b0, in_rd = 1'b0, seg_read = 1'b0;
  int         nbits = 0, ack_n = 0, mi = 0, mk = 0;
  logic [7:0] shreg = 8'h00, exp_data = 8'h00;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;

  always @(negedge clk_pll) begin
    if (rst) begin
      nbits = 0; seg_read = 1'b0; in_txn = 1'b0; in_rd = 1'b0; ack_n = 0;
      exp_data = 8'h00; slave_bit = 1'b1; prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      mi = nbits % 9;
      mk = nbits / 9;
      if (prev_scl && scl && prev_sda && !sda) begin
        frames.push_back(M_START);
        nbits = 0; seg_read = 1'b0; in_txn = 1'b1; shreg = 8'h00;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        frames.push_back(M_STOP);
        in_txn = 1'b0; ack_n = 0; stop_count++;
        if (cur_sel != 4'd14 && nack_at < 0) exp_data = cur_byte;
      end else if (!prev_scl && scl) begin
        if (mi < 8) begin
          shreg = {shreg[6:0], sda};
          chk("bit_tristate", int'(tristate), int'(seg_read && mk == 1));
        end else begin
          frames.push_back(int'({shreg, sda}));
          if (seg_read && mk == 1) chk("nack_tristate", int'(tristate), 0);
          else                     chk("ack_tristate", int'(tristate), 1);
          if (mk == 0) seg_read = shreg[0];
        end
        nbits++;
      end else if (prev_scl && !scl) begin
        if (seg_read && mk == 1) begin
          slave_bit = (mi < 8) ? cur_byte[7 - mi] : 1'b1;
        end else if (mi == 8) begin
          slave_bit = (ack_n == nack_at) ? 1'b1 : 1'b0;
          ack_n++;
        end else begin
          slave_bit = 1'b1;
        end
      end
      in_rd = in_txn && seg_read && (nbits / 9 == 1);
      if (mon_en && !in_txn) begin
        chk("idle_scl", int'(scl), 1);
        chk("idle_sda", int'(sda), 1);
        chk("idle_tristate", int'(tristate), 0);
        chk("idle_data", int'(data), int'(exp_data));
      end
      prev_scl = scl;
      prev_sda = sda;
    end
  end

  function automatic int fr(input int idx);
    return (idx < frames.size()) ? frames[idx] : -1;
  endfunction

  task automatic build_exp(input logic [3:0] sel, input logic [7:0] sb, input int nk);
    logic [7:0] ra;
    ra = (sel < 4'd14) ? 8'h3B + {4'd0, sel} : ((sel == 4'd14) ? 8'h6B : 8'h75);
    exp_q.delete();
    exp_q.push_back(M_START);
    exp_q.push_back(int'({8'hD0, nk == 0}));
    if (nk == 0) begin exp_q.push_back(M_STOP); return; end
    exp_q.push_back(int'({ra, nk == 1}));
    if (nk == 1) begin exp_q.push_back(M_STOP); return; end
    if (sel == 4'd14) begin
      exp_q.push_back(int'({8'h00, nk == 2}));
      exp_q.push_back(M_STOP);
      return;
    end
    exp_q.push_back(M_START);
    exp_q.push_back(int'({8'hD1, nk == 2}));
    if (nk == 2) begin exp_q.push_back(M_STOP); return; end
    exp_q.push_back(int'({sb, 1'b1}));
    exp_q.push_back(M_STOP);
  endtask

  task automatic wait_stop(input int target, input int budget);
    for (int i = 0; i < budget && stop_count < target; i++) @(posedge clk_pll);
    chk("stop_seen", int'(stop_count >= target), 1);
  endtask

  logic [7:0] mdata = 8'h00;

  task automatic run_txn(input logic [3:0] sel, input logic [7:0] sb, input int nk,
                         input int pulse, input bit scramble, input int gap, output int base);
    int t0, sc;
    cur_sel = sel; cur_byte = sb; nack_at = nk;
    base = frames.size();
    sc = stop_count;
    @(posedge clk_pll); #1;
    register_selector = sel;
    en = 1'b1;
    t0 = cycle;
    repeat (pulse) @(posedge clk_pll);
    #1 en = 1'b0;
    if (scramble) register_selector = 4'($urandom);
    wait_stop(sc + 1, 3000);
    chk("duration_ok", int'((cycle - t0) <= 1680), 1);
    build_exp(sel, sb, nk);
    chk("frame_len", frames.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) chk("frame_item", fr(base + i), exp_q[i]);
    if (sel != 4'd14 && nk < 0) mdata = sb;
    repeat (40) @(posedge clk_pll);
    #1 chk("data_after", int'(data), int'(mdata));
    while (cycle < t0 + gap) @(posedge clk_pll);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    int base, sc;
    rst = 1'b1;
    repeat (3) @(posedge clk_pll);
    #1 rst = 1'b0;
    @(negedge clk_pll);
    chk("rst_scl", int'(scl), 1);
    chk("rst_sda", int'(sda), 1);
    chk("rst_tristate", int'(tristate), 0);
    chk("rst_data", int'(data), 8'h00);
    mon_en = 1'b1;

    // Selector 0 with the slave holding sda low; frame pinned literally.
    run_txn(4'd0, 8'h00, -1, 5, 1'b0, 2500, base);
    chk("lit_start", fr(base), M_START);
    chk("lit_addr_w", fr(base + 1), 'h1A0);
    chk("lit_reg", fr(base + 2), 'h076);
    chk("lit_rstart", fr(base + 3), M_START);
    chk("lit_addr_r", fr(base + 4), 'h1A2);
    chk("lit_rdata", fr(base + 5), 'h001);
    chk("lit_stop", fr(base + 6), M_STOP);
    chk("lit_data", int'(data), 8'h00);

    for (int s = 0; s < 16; s++) run_txn(4'(s), 8'hA5, -1, 5, 1'b0, 2500, base);
    chk("lit_data_a5", int'(data), 8'hA5);

    // NACK on the address byte aborts straight to STOP.
    run_txn(4'd2, 8'h3C, 0, 5, 1'b0, 2500, base);
    chk("lit_nack_len", frames.size() - base, 3);
    chk("lit_nack_addr", fr(base + 1), 'h1A1);
    chk("lit_nack_data", int'(data), 8'hA5);

    // en held high, then a second rising edge mid-transaction: one transaction only.
    cur_sel = 4'd7; cur_byte = 8'h5A; nack_at = -1;
    base = frames.size();
    sc = stop_count;
    @(posedge clk_pll); #1 register_selector = 4'd7; en = 1'b1;
    repeat (500) @(posedge clk_pll);
    #1 en = 1'b0;
    repeat (10) @(posedge clk_pll);
    #1 en = 1'b1;
    repeat (2000) @(posedge clk_pll);
    #1 en = 1'b0;
    repeat (1500) @(posedge clk_pll);
    chk("held_one_txn", stop_count - sc, 1);
    build_exp(4'd7, 8'h5A, -1);
    chk("held_frame_len", frames.size() - base, exp_q.size());
    mdata = 8'h5A;
    chk("held_data", int'(data), 8'h5A);

    // Reset while the read byte is on the bus.
    cur_sel = 4'd3; cur_byte = 8'hC3; nack_at = -1;
    @(posedge clk_pll); #1 register_selector = 4'd3; en = 1'b1;
    repeat (5) @(posedge clk_pll);
    #1 en = 1'b0;
    for (int i = 0; i < 3000 && !in_rd; i++) @(posedge clk_pll);
    chk("reached_read", int'(in_rd), 1);
    repeat (30) @(posedge clk_pll);
    #1 rst = 1'b1;
    @(posedge clk_pll);
    #1;
    chk("midrst_scl", int'(scl), 1);
    chk("midrst_tristate", int'(tristate), 0);
    chk("midrst_sda", int'(sda), 1);
    chk("midrst_data", int'(data), 8'h00);
    rst = 1'b0;
    mdata = 8'h00;
    repeat (50) @(posedge clk_pll);
    run_txn(4'd15, 8'h68, -1, 3, 1'b0, 1800, base);

    for (int r = 0; r < 6; r++) begin
      int nk;
      nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_txn(4'($urandom_range(0, 15)), 8'($urandom), nk, int'($urandom_range(1, 40)), 1'b1, 1800, base);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
